// File: rtl/tiq_adc_seq.sv
// rtl/tiq_adc_seq.sv - TIQ flash ADC conversion sequencer
// Strobes the comparator bank, syncs and decodes thermometer codes, accumulates samples.
module tiq_adc_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       cont,
  input  logic [1:0] osr_log2,
  input  logic [7:0] period,
  input  logic [6:0] therm,
  input  logic       clr_flags,
  output logic       samp_en,
  output logic       busy,
  output logic [5:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       overrun,
  output logic       bubble_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 2);

  state_t     state;
  logic [6:0] sync_q [SYNC_STAGES];
  logic [6:0] therm_s;
  logic [2:0] code;
  logic       therm_legal;
  logic [5:0] acc;
  logic [5:0] acc_next;
  logic [3:0] smp_cnt;
  logic [3:0] cnt_next;
  logic [3:0] smp_target;
  logic [1:0] osr_sh;
  logic [7:0] per_sh;
  logic [7:0] per_eff;
  logic [7:0] tmr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= therm;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign therm_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    code = '0;
    for (int i = 0; i < 7; i++) code = code + {2'b00, therm_s[i]};
  end

  // A legal code is a run of ones from the LSB: adding one clears every set bit.
  assign therm_legal = (((therm_s + 7'd1) & therm_s) == 7'd0);
  assign acc_next    = acc + {3'b000, code};
  assign cnt_next    = smp_cnt + 4'd1;
  assign smp_target  = 4'd1 << osr_sh;
  assign per_eff     = (period == 8'd0) ? 8'd1 : period;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      samp_en    <= 1'b0;
      busy       <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      bubble_err <= 1'b0;
      acc        <= '0;
      smp_cnt    <= '0;
      osr_sh     <= '0;
      per_sh     <= '0;
      tmr        <= '0;
    end else begin
      if (clr_flags) begin
        overrun    <= 1'b0;
        bubble_err <= 1'b0;
      end
      if (data_valid && data_ready) data_valid <= 1'b0;

      // A completed result in DONE is still published when ena drops.
      if (!ena && state != S_IDLE && state != S_DONE) begin
        state   <= S_IDLE;
        samp_en <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (ena && (start || cont)) begin
              osr_sh  <= osr_log2;
              per_sh  <= per_eff;
              acc     <= '0;
              smp_cnt <= '0;
              tmr     <= '0;
              samp_en <= 1'b1;
              busy    <= 1'b1;
              state   <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (tmr == SETTLE_LAST) state <= S_CAPTURE;
            else tmr <= tmr + 8'd1;
          end
          S_CAPTURE: begin
            acc     <= acc_next;
            smp_cnt <= cnt_next;
            tmr     <= '0;
            samp_en <= 1'b0;
            if (!therm_legal) bubble_err <= 1'b1;
            state <= (cnt_next == smp_target) ? S_DONE : S_WAIT;
          end
          S_WAIT: begin
            if (tmr == per_sh - 8'd1) begin
              tmr     <= '0;
              samp_en <= 1'b1;
              state   <= S_SETTLE;
            end else begin
              tmr <= tmr + 8'd1;
            end
          end
          S_DONE: begin
            if (!data_valid || data_ready) begin
              data       <= acc;
              data_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            if (cont && ena) begin
              osr_sh  <= osr_log2;
              per_sh  <= per_eff;
              acc     <= '0;
              smp_cnt <= '0;
              tmr     <= '0;
              state   <= S_WAIT;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: begin
            state   <= S_IDLE;
            samp_en <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
